// File: rtl/ex_muldiv_unit.sv
// Iterative 32x32 multiply/divide unit for the EX stage; owns the HI/LO registers.
// One multiplier/quotient bit per cycle, sign fix-up in a final cycle, stall request while busy.
module ex_muldiv_unit (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        flush,
    input  logic [31:0] OperandA,
    input  logic [31:0] OperandB,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        hilo_read,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic        busy,
    output logic        done,
    output logic        stall_req
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic        is_div_q, is_div_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic        div0_q, div0_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        sign_a, sign_b;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_top, div_diff;
    logic        div_ge;
    logic [63:0] div_next;
    logic [63:0] prod_fix;

    always_comb begin
        sign_a = ~op[0] & OperandA[31];
        sign_b = ~op[0] & OperandB[31];
        abs_a  = sign_a ? (32'd0 - OperandA) : OperandA;
        abs_b  = sign_b ? (32'd0 - OperandB) : OperandB;

        // Multiply: multiplier sits in acc low half and shifts out as the product shifts in.
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};

        // Divide: acc = {remainder, dividend}, quotient bits enter at the bottom.
        div_top  = acc_q[63:31];
        div_ge   = div_top >= {1'b0, opnd_q};
        div_diff = div_top - {1'b0, opnd_q};
        div_next = {(div_ge ? div_diff[31:0] : div_top[31:0]), acc_q[30:0], div_ge};

        prod_fix = neg_lo_q ? (64'd0 - acc_q) : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            StIdle: begin
                if (!flush) begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                    if (start) begin
                        state_d  = StCalc;
                        cnt_d    = 5'd0;
                        is_div_d = op[1];
                        neg_lo_d = sign_a ^ sign_b;
                        neg_hi_d = sign_a;
                        div0_d   = (OperandB == 32'd0);
                        a_raw_d  = OperandA;
                        acc_d    = {32'd0, (op[1] ? abs_a : abs_b)};
                        opnd_d   = op[1] ? abs_b : abs_a;
                    end
                end
            end
            StCalc: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = StFix;
            end
            StFix: begin
                state_d = StIdle;
                if (!is_div_q) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (div0_q) begin
                    hi_d = a_raw_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
                    lo_d = neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_q == StFix);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            a_raw_q  <= 32'd0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign HI_out    = hi_q;
    assign LO_out    = lo_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign stall_req = busy_q & (start | hilo_read | hi_we | lo_we);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected {HI,LO} queued at issue, checked on done.
// Directed cases for latency, stall, MTHI/MTLO, flush and reset, then random operations.
module tb_ex_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Rst, start, flush, hi_we, lo_we, hilo_read;
    logic [1:0]  op;
    logic [31:0] OperandA, OperandB, wdata;
    logic [31:0] HI_out, LO_out;
    logic        busy, done, stall_req;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    ex_muldiv_unit dut (
        .Clk(Clk), .Rst(Rst), .start(start), .op(op), .flush(flush),
        .OperandA(OperandA), .OperandB(OperandB), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .hilo_read(hilo_read), .HI_out(HI_out), .LO_out(LO_out),
        .busy(busy), .done(done), .stall_req(stall_req)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero like the ISA.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                q = sa * sb;
                p = q;
            end
            2'b01: p = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    always @(negedge Clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else check("result_hilo", {HI_out, LO_out}, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Waits until busy drops; returns the number of edges it took.
    task automatic wait_idle(input bit hold_read, output int n, output int bad);
        n = 0;
        bad = 0;
        while (busy === 1'b1 && n < 60) begin
            hilo_read = hold_read;
            #0;
            if (stall_req !== hold_read) bad++;
            tick();
            n++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit hold_read);
        int n, bad;
        start = 1'b1; op = o; OperandA = a; OperandB = b;
        exp_q.push_back(model(o, a, b));
        tick();
        start = 1'b0;
        wait_idle(hold_read, n, bad);
        check("busy_cycles", 64'(n), 64'd33);
        check("stall_while_busy", 64'(bad), 64'd0);
        check("done_after_fix", {63'd0, done}, 64'd1);
        check("stall_after_idle", {63'd0, stall_req}, 64'd0);
        hilo_read = 1'b0;
        tick();
        check("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        int n, bad, dones;
        logic [31:0] saved;
        logic [31:0] edges [6];
        edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

        Rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        hilo_read = 1'b0; op = 2'b00; OperandA = '0; OperandB = '0; wdata = '0;
        repeat (3) tick();
        Rst = 1'b0;
        check("reset_hi", {32'd0, HI_out}, 64'd0);
        check("reset_lo", {32'd0, LO_out}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        hilo_read = 1'b1;
        #0;
        check("reset_stall", {63'd0, stall_req}, 64'd0);
        hilo_read = 1'b0;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b11, 32'h1234_5678, 32'd0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // MFHI held from E0+1: stalled until the result is visible.
        run_op(2'b01, 32'd3, 32'd5, 1'b1);
        check("stall_release_hilo", {HI_out, LO_out}, 64'd15);

        start = 1'b1; flush = 1'b1; op = 2'b01; OperandA = 32'd9; OperandB = 32'd9;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flushed_start_busy", {63'd0, busy}, 64'd0);

        saved = LO_out;
        hi_we = 1'b1; wdata = 32'hCAFE_F00D;
        tick();
        hi_we = 1'b0;
        check("mthi_hi", {32'd0, HI_out}, 64'hCAFE_F00D);
        check("mthi_lo_kept", {32'd0, LO_out}, {32'd0, saved});

        // MTLO during busy is stalled and ignored.
        start = 1'b1; op = 2'b11; OperandA = 32'd100; OperandB = 32'd7;
        exp_q.push_back(model(2'b11, 32'd100, 32'd7));
        tick();
        start = 1'b0;
        saved = LO_out;
        lo_we = 1'b1; wdata = 32'h5555_AAAA;
        #0;
        check("mtlo_busy_stall", {63'd0, stall_req}, 64'd1);
        tick();
        lo_we = 1'b0;
        check("mtlo_busy_lo_kept", {32'd0, LO_out}, {32'd0, saved});
        wait_idle(1'b0, n, bad);
        check("mtlo_busy_finish", 64'(n), 64'd32);
        tick();

        // Reset at E0+10 aborts with no done pulse.
        start = 1'b1; op = 2'b11; OperandA = 32'hDEAD_BEEF; OperandB = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("rst_abort_busy", {63'd0, busy}, 64'd0);
        check("rst_abort_done", {63'd0, done}, 64'd0);
        check("rst_abort_hilo", {HI_out, LO_out}, 64'd0);
        dones = 0;
        repeat (30) begin
            tick();
            if (done === 1'b1) dones++;
        end
        check("rst_no_done", 64'(dones), 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 1) == 0) b = b >> $urandom_range(0, 31);
            run_op(2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)));
        end

        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
